// File: rtl/tea_stream_pkg.sv
// Shared constants and state encoding for the TEA stream upsizer slice.
package tea_stream_pkg;

  localparam int TEA_BLOCK_W = 64;
  localparam int DEF_TID_W   = 8;
  localparam int DEF_TDEST_W = 3;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_HAVE_LO = 1'b1
  } state_e;

endpackage

// File: rtl/tea_stream_out_reg.sv
// One-entry valid/ready output register. It loads on (load && slot_free)
// and reports slot_free so the producer can decide to accept upstream.
module tea_stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] next_payload,
  output logic         valid,
  output logic [W-1:0] payload,
  output logic         slot_free
);

  assign slot_free = !valid || ready;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load && slot_free) begin
      valid   <= 1'b1;
      payload <= next_payload;
    end else if (ready) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/tea_stream_upsizer.sv
// AXI4-Stream 2:1 upsizer packing 32-bit beats into 64-bit TEA blocks.
// Optional TUSER pass-through is enabled with `define AMBA_AXI_TUSER_EN.
module tea_stream_upsizer
  import tea_stream_pkg::*;
#(
  parameter int S_WIDTH_DATA       = TEA_BLOCK_W / 2,
  parameter int S_WIDTH_DS         = S_WIDTH_DATA / 8,
  parameter int STREAM_WIDTH_TID   = DEF_TID_W,
  parameter int STREAM_WIDTH_TDEST = DEF_TDEST_W,
  parameter int STREAM_WIDTH_TUSER = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  output logic                          S_TREADY,
  input  logic                          S_TVALID,
  input  logic [S_WIDTH_DATA-1:0]       S_TDATA,
  input  logic [S_WIDTH_DS-1:0]         S_TSTRB,
  input  logic [S_WIDTH_DS-1:0]         S_TKEEP,
  input  logic                          S_TLAST,
  input  logic [STREAM_WIDTH_TID-1:0]   S_TID,
  input  logic [STREAM_WIDTH_TDEST-1:0] S_TDEST,
`ifdef AMBA_AXI_TUSER_EN
  input  logic [STREAM_WIDTH_TUSER-1:0] S_TUSER,
`endif
  input  logic                          M_TREADY,
  output logic                          M_TVALID,
  output logic [2*S_WIDTH_DATA-1:0]     M_TDATA,
  output logic [2*S_WIDTH_DS-1:0]       M_TSTRB,
  output logic [2*S_WIDTH_DS-1:0]       M_TKEEP,
  output logic                          M_TLAST,
`ifdef AMBA_AXI_TUSER_EN
  output logic [STREAM_WIDTH_TUSER-1:0] M_TUSER,
`endif
  output logic [STREAM_WIDTH_TID-1:0]   M_TID,
  output logic [STREAM_WIDTH_TDEST-1:0] M_TDEST
);

  localparam int M_WIDTH_DATA = 2 * S_WIDTH_DATA;
  localparam int M_WIDTH_DS   = 2 * S_WIDTH_DS;
`ifdef AMBA_AXI_TUSER_EN
  localparam int TUSER_EN = 1;
`else
  localparam int TUSER_EN = 0;
`endif
  localparam int PAY_W = M_WIDTH_DATA + 2 * M_WIDTH_DS + 1 + STREAM_WIDTH_TID
                       + STREAM_WIDTH_TDEST + TUSER_EN * STREAM_WIDTH_TUSER;

  state_e state, state_nxt;

  logic [S_WIDTH_DATA-1:0]       lo_data;
  logic [S_WIDTH_DS-1:0]         lo_strb;
  logic [S_WIDTH_DS-1:0]         lo_keep;
  logic [STREAM_WIDTH_TID-1:0]   lo_id;
  logic [STREAM_WIDTH_TDEST-1:0] lo_dest;
  logic                          lo_we;

  logic                          load;
  logic                          slot_free;
  logic                          ready_int;
  logic                          match;
  logic [M_WIDTH_DATA-1:0]       o_data;
  logic [M_WIDTH_DS-1:0]         o_strb;
  logic [M_WIDTH_DS-1:0]         o_keep;
  logic                          o_last;
  logic [STREAM_WIDTH_TID-1:0]   o_id;
  logic [STREAM_WIDTH_TDEST-1:0] o_dest;
  logic [PAY_W-1:0]              next_payload;
  logic [PAY_W-1:0]              payload;

`ifdef AMBA_AXI_TUSER_EN
  logic [STREAM_WIDTH_TUSER-1:0] lo_user;
  logic [STREAM_WIDTH_TUSER-1:0] o_user;
`endif

  assign match = (S_TID == lo_id) && (S_TDEST == lo_dest);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    ready_int = 1'b0;
    lo_we     = 1'b0;
    load      = 1'b0;
    o_data    = '0;
    o_strb    = '0;
    o_keep    = '0;
    o_last    = 1'b0;
    o_id      = '0;
    o_dest    = '0;
`ifdef AMBA_AXI_TUSER_EN
    o_user    = '0;
`endif
    case (state)
      ST_EMPTY: begin
        ready_int = slot_free;
        if (S_TVALID && slot_free) begin
          if (S_TLAST) begin
            load                      = 1'b1;
            o_data[S_WIDTH_DATA-1:0]  = S_TDATA;
            o_strb[S_WIDTH_DS-1:0]    = S_TSTRB;
            o_keep[S_WIDTH_DS-1:0]    = S_TKEEP;
            o_last                    = 1'b1;
            o_id                      = S_TID;
            o_dest                    = S_TDEST;
`ifdef AMBA_AXI_TUSER_EN
            o_user                    = S_TUSER;
`endif
          end else begin
            lo_we     = 1'b1;
            state_nxt = ST_HAVE_LO;
          end
        end
      end
      ST_HAVE_LO: begin
        if (S_TVALID) begin
          // A mismatching beat flushes the low half alone; upper half stays zero.
          o_data[S_WIDTH_DATA-1:0] = lo_data;
          o_strb[S_WIDTH_DS-1:0]   = lo_strb;
          o_keep[S_WIDTH_DS-1:0]   = lo_keep;
          o_id                     = lo_id;
          o_dest                   = lo_dest;
`ifdef AMBA_AXI_TUSER_EN
          o_user                   = lo_user;
`endif
          if (match) begin
            ready_int                                = slot_free;
            o_data[M_WIDTH_DATA-1:S_WIDTH_DATA]      = S_TDATA;
            o_strb[M_WIDTH_DS-1:S_WIDTH_DS]          = S_TSTRB;
            o_keep[M_WIDTH_DS-1:S_WIDTH_DS]          = S_TKEEP;
            o_last                                   = S_TLAST;
`ifdef AMBA_AXI_TUSER_EN
            o_user                                   = lo_user | S_TUSER;
`endif
          end
          if (slot_free) begin
            load      = 1'b1;
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign S_TREADY = ready_int && !ARESET;

  // NOTE: the holding register is reset too, so stale half-blocks never survive a reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ST_EMPTY;
      lo_data <= '0;
      lo_strb <= '0;
      lo_keep <= '0;
      lo_id   <= '0;
      lo_dest <= '0;
`ifdef AMBA_AXI_TUSER_EN
      lo_user <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (lo_we) begin
        lo_data <= S_TDATA;
        lo_strb <= S_TSTRB;
        lo_keep <= S_TKEEP;
        lo_id   <= S_TID;
        lo_dest <= S_TDEST;
`ifdef AMBA_AXI_TUSER_EN
        lo_user <= S_TUSER;
`endif
      end
    end
  end

`ifdef AMBA_AXI_TUSER_EN
  assign next_payload = {o_user, o_last, o_id, o_dest, o_keep, o_strb, o_data};
  assign {M_TUSER, M_TLAST, M_TID, M_TDEST, M_TKEEP, M_TSTRB, M_TDATA} = payload;
`else
  assign next_payload = {o_last, o_id, o_dest, o_keep, o_strb, o_data};
  assign {M_TLAST, M_TID, M_TDEST, M_TKEEP, M_TSTRB, M_TDATA} = payload;
`endif

  tea_stream_out_reg #(.W(PAY_W)) u_out_reg (
    .clk          (ACLK),
    .rst          (ARESET),
    .load         (load),
    .ready        (M_TREADY),
    .next_payload (next_payload),
    .valid        (M_TVALID),
    .payload      (payload),
    .slot_free    (slot_free)
  );

endmodule
